// File: rtl/cmpx_mac_pkg.sv
// Shared types and constants for the complex multiply-accumulate sequencer.
package cmpx_mac_pkg;

    localparam int OP_W    = 8;   // packed operand {re[7:4], im[3:0]}
    localparam int PROD_W  = 16;  // packed product {re[15:8], im[7:0]}
    localparam int FIELD_W = 8;   // width of one signed product field

    localparam int RE_HI = 15;
    localparam int RE_LO = 8;
    localparam int IM_HI = 7;
    localparam int IM_LO = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_SETTLE,
        S_WAIT,
        S_ACC,
        S_DONE
    } state_t;

endpackage

// File: rtl/cmpx_mac_seq_if.sv
// Operand stream and multiplier-side signals of the MAC sequencer.
//
// Handshake: an operand pair moves on a rising edge where in_valid and
// in_ready are both high. in_ready depends only on the sequencer state,
// never on in_valid; the producer must hold a_in/b_in stable while
// in_valid is high and not yet accepted. On the multiplier side,
// mult_start is a one-cycle request and mult_done marks mult_out valid.
interface cmpx_mac_seq_if;
    import cmpx_mac_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   a_in;
    logic [OP_W-1:0]   b_in;
    logic [OP_W-1:0]   mult_a;
    logic [OP_W-1:0]   mult_b;
    logic              mult_start;
    logic              mult_done;
    logic [PROD_W-1:0] mult_out;

    // Environment side: operand producer and the multiplier.
    modport master (
        output in_valid, a_in, b_in, mult_done, mult_out,
        input  in_ready, mult_a, mult_b, mult_start
    );

    // Sequencer side.
    modport slave (
        input  in_valid, a_in, b_in, mult_done, mult_out,
        output in_ready, mult_a, mult_b, mult_start
    );

endinterface

// File: rtl/cmpx_acc_reg.sv
// One signed accumulator component: clear, or add a sign-extended
// 8-bit product field. Sums wrap modulo 2^ACC_W.
module cmpx_acc_reg
    import cmpx_mac_pkg::*;
#(
    parameter int ACC_W = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               load,
    input  logic [FIELD_W-1:0] prod,
    output logic [ACC_W-1:0]   acc
);

    // Accumulator register: clear has priority over load.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc <= '0;
        end else if (load) begin
            acc <= acc + ACC_W'($signed(prod));
        end
    end

endmodule

// File: rtl/cmpx_mac_seq.sv
// Sequencer feeding operand pairs to an external complex multiplier and
// accumulating the returned {re, im} products over a run of n_terms.
module cmpx_mac_seq
    import cmpx_mac_pkg::*;
#(
    parameter int ACC_W = 12,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] n_terms,
    cmpx_mac_seq_if.slave    bus,
    output logic [ACC_W-1:0] acc_re,
    output logic [ACC_W-1:0] acc_im,
    output logic             busy,
    output logic             done,
    output state_t           state_dbg
);

    state_t            state;
    state_t            nxt;
    logic [CNT_W-1:0]  cnt;
    logic [OP_W-1:0]   op_a;
    logic [OP_W-1:0]   op_b;
    logic [PROD_W-1:0] prod_q;
    logic              acc_clr;
    logic              acc_load;
    logic              in_ready_c;
    logic              mult_start_c;

    assign bus.in_ready   = in_ready_c;
    assign bus.mult_start = mult_start_c;
    assign bus.mult_a     = op_a;
    assign bus.mult_b     = op_b;
    assign state_dbg      = state;

    // State register, term counter, operand and product registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            op_a   <= '0;
            op_b   <= '0;
            prod_q <= '0;
        end else begin
            state <= nxt;
            if (state == S_IDLE && start && n_terms != '0) begin
                cnt <= n_terms;
            end
            // Operands change only on acceptance, so they stay stable
            // while the multiplier works on them.
            if (state == S_FETCH && bus.in_valid) begin
                op_a <= bus.a_in;
                op_b <= bus.b_in;
            end
            // SETTLE is skipped here on purpose: a done level left over
            // from the previous product must not be captured.
            if (state == S_WAIT && bus.mult_done) begin
                prod_q <= bus.mult_out;
            end
            if (state == S_ACC) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Next-state and per-state output decode.
    always_comb begin
        nxt          = state;
        in_ready_c   = 1'b0;
        mult_start_c = 1'b0;
        busy         = (state != S_IDLE);
        done         = 1'b0;
        acc_clr      = 1'b0;
        acc_load     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    acc_clr = 1'b1;
                    nxt     = (n_terms != '0) ? S_FETCH : S_DONE;
                end
            end
            S_FETCH: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) nxt = S_ISSUE;
            end
            S_ISSUE: begin
                mult_start_c = 1'b1;
                nxt          = S_SETTLE;
            end
            S_SETTLE: nxt = S_WAIT;
            S_WAIT: begin
                if (bus.mult_done) nxt = S_ACC;
            end
            S_ACC: begin
                acc_load = 1'b1;
                nxt      = (cnt == CNT_W'(1)) ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                done = 1'b1;
                nxt  = S_IDLE;
            end
            default: nxt = S_IDLE;
        endcase
    end

    cmpx_acc_reg #(.ACC_W(ACC_W)) u_acc_re (
        .clk  (clk),
        .rst  (rst),
        .clr  (acc_clr),
        .load (acc_load),
        .prod (prod_q[RE_HI:RE_LO]),
        .acc  (acc_re)
    );

    cmpx_acc_reg #(.ACC_W(ACC_W)) u_acc_im (
        .clk  (clk),
        .rst  (rst),
        .clr  (acc_clr),
        .load (acc_load),
        .prod (prod_q[IM_HI:IM_LO]),
        .acc  (acc_im)
    );

endmodule

// File: tb/tb_cmpx_mac_seq.sv
// Bench for cmpx_mac_seq: two instances (12-bit and 8-bit accumulators)
// driven in lockstep, a behavioural complex multiplier with a sticky done
// level, and a scoreboard that checks each run at its done pulse.
module tb_cmpx_mac_seq;
    import cmpx_mac_pkg::*;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] n_terms = 4'd0;
    int         cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT wiring ----------------
    logic        tv = 1'b0;
    logic [7:0]  ta = 8'd0;
    logic [7:0]  tb_b = 8'd0;
    logic        mdone = 1'b0;
    logic [15:0] mout = 16'd0;
    logic        inj_done = 1'b0;
    logic [15:0] inj_out = 16'd0;

    cmpx_mac_seq_if if_a ();
    cmpx_mac_seq_if if_b ();

    assign if_a.in_valid  = tv;
    assign if_a.a_in      = ta;
    assign if_a.b_in      = tb_b;
    assign if_a.mult_done = mdone | inj_done;
    assign if_a.mult_out  = inj_done ? inj_out : mout;
    assign if_b.in_valid  = tv;
    assign if_b.a_in      = ta;
    assign if_b.b_in      = tb_b;
    assign if_b.mult_done = mdone | inj_done;
    assign if_b.mult_out  = inj_done ? inj_out : mout;

    logic [11:0] acc_re_a, acc_im_a;
    logic [7:0]  acc_re_b, acc_im_b;
    logic        busy_a, busy_b, done_a, done_b;
    state_t      st_a, st_b;

    cmpx_mac_seq #(.ACC_W(12), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst), .start(start), .n_terms(n_terms), .bus(if_a),
        .acc_re(acc_re_a), .acc_im(acc_im_a), .busy(busy_a), .done(done_a),
        .state_dbg(st_a)
    );

    cmpx_mac_seq #(.ACC_W(8), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .start(start), .n_terms(n_terms), .bus(if_b),
        .acc_re(acc_re_b), .acc_im(acc_im_b), .busy(busy_b), .done(done_b),
        .state_dbg(st_b)
    );

    // ---------------- multiplier model ----------------
    // Latency M counted from the edge that samples mult_start; done stays
    // high (with the old product) until the next product is being formed.
    int m_fixed = 0;
    int mcnt = 0;
    bit mbusy = 1'b0;

    function automatic logic [15:0] cmul(input logic [7:0] a, input logic [7:0] b);
        int re;
        int im;
        re = int'(a[7:4]) * int'(b[7:4]) - int'(a[3:0]) * int'(b[3:0]);
        im = int'(a[7:4]) * int'(b[3:0]) + int'(a[3:0]) * int'(b[7:4]);
        return {re[7:0], im[7:0]};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mdone <= 1'b0;
            mout  <= 16'd0;
            mbusy <= 1'b0;
            mcnt  <= 0;
        end else if (if_a.mult_start) begin
            mbusy <= 1'b1;
            mcnt  <= (m_fixed > 0) ? m_fixed : int'($urandom_range(1, 4));
        end else if (mbusy) begin
            if (mcnt == 1) begin
                mdone <= 1'b1;
                mout  <= cmul(if_a.mult_a, if_a.mult_b);
                mbusy <= 1'b0;
            end else begin
                mdone <= 1'b0;
                mcnt  <= mcnt - 1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_re_q[$];
    logic [31:0] exp_im_q[$];
    int          exp_st_q[$];
    int          exp_lat_q[$];
    int          run_t0 = 0;
    int          run_base = 0;
    int          starts_total = 0;
    logic        done_prev = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            done_prev <= 1'b0;
        end else begin
            if (done_prev) check("done_one_cycle", done_a, 0);
            done_prev <= done_a;
            if (if_a.mult_start) starts_total <= starts_total + 1;
            if (done_a) begin
                if (exp_re_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL spurious_done: got done=1, expected no run in flight");
                end else begin
                    check("acc_re_w12", acc_re_a, exp_re_q[0] & 32'hFFF);
                    check("acc_im_w12", acc_im_a, exp_im_q[0] & 32'hFFF);
                    check("acc_re_w8", acc_re_b, exp_re_q[0] & 32'hFF);
                    check("acc_im_w8", acc_im_b, exp_im_q[0] & 32'hFF);
                    check("done_w8", done_b, 1);
                    check("busy_at_done", busy_a, 1);
                    check("mult_start_count", starts_total - run_base, exp_st_q[0]);
                    if (exp_lat_q[0] >= 0) check("run_latency", cyc - run_t0, exp_lat_q[0]);
                    void'(exp_re_q.pop_front());
                    void'(exp_im_q.pop_front());
                    void'(exp_st_q.pop_front());
                    void'(exp_lat_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    logic [7:0] qa[$];
    logic [7:0] qb[$];

    task automatic issue_start(input int n);
        @(negedge clk);
        start    = 1'b1;
        n_terms  = n[3:0];
        run_t0   = cyc;
        run_base = starts_total;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Present one pair, optionally after a stall (with an optional stray
    // start pulse in the middle of it), and return just after acceptance.
    task automatic feed(input logic [7:0] a, input logic [7:0] b,
                        input int stall, input bit poke);
        int k;
        tv = 1'b0;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            start   = poke && (i == 2);
            n_terms = 4'd7;
        end
        start = 1'b0;
        tv    = 1'b1;
        ta    = a;
        tb_b  = b;
        k     = 0;
        while (!if_a.in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) check("in_ready_timeout", k, 0);
        @(posedge clk);
        #1;
        tv = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (busy_a && k < 500);
        if (k >= 500) check("run_timeout", k, 0);
    endtask

    // Expected sum is plain complex arithmetic over the pairs handed out.
    task automatic run(input int n, input int mfix, input bit lat_chk,
                       input int stall_idx, input bit poke, input bit gaps);
        int sre;
        int sim;
        int st;
        sre = 0;
        sim = 0;
        for (int i = 0; i < n; i++) begin
            sre += int'(qa[i][7:4]) * int'(qb[i][7:4]) - int'(qa[i][3:0]) * int'(qb[i][3:0]);
            sim += int'(qa[i][7:4]) * int'(qb[i][3:0]) + int'(qa[i][3:0]) * int'(qb[i][7:4]);
        end
        exp_re_q.push_back(sre);
        exp_im_q.push_back(sim);
        exp_st_q.push_back(n);
        exp_lat_q.push_back(lat_chk ? 1 + n * (4 + mfix) : -1);
        m_fixed = mfix;
        issue_start(n);
        for (int i = 0; i < n; i++) begin
            st = (i == stall_idx) ? 5 : (gaps ? int'($urandom_range(0, 2)) : 0);
            feed(qa[i], qb[i], st, poke && (i == stall_idx));
        end
        wait_idle();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("rst_in_ready", if_a.in_ready, 0);
        check("rst_mult_start", if_a.mult_start, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_mult_a", if_a.mult_a, 0);
        check("rst_mult_b", if_a.mult_b, 0);
        check("rst_acc_re", acc_re_a, 0);
        check("rst_acc_im", acc_im_a, 0);
        check("rst_state", st_a, S_IDLE);
        check("rst_w8_busy", busy_b, 0);
        check("rst_w8_in_ready", if_b.in_ready, 0);
        check("rst_w8_mult_start", if_b.mult_start, 0);
        check("rst_w8_mult_ab", {if_b.mult_a, if_b.mult_b}, 0);
        check("rst_w8_acc", {acc_re_b, acc_im_b}, 0);
        rst = 1'b0;

        // Single term: (2+3j)(2+1j) = 1 + 8j
        qa = '{8'h23};
        qb = '{8'h21};
        run(1, 2, 1'b1, -1, 1'b0, 1'b0);
        check("single_re_const", acc_re_a, 12'd1);
        check("single_im_const", acc_im_a, 12'd8);

        // Three terms: 1+8j, -2+6j, 1+3j -> 0 + 17j
        qa = '{8'h23, 8'h22, 8'h10};
        qb = '{8'h21, 8'h12, 8'h13};
        run(3, 1, 1'b1, -1, 1'b0, 1'b0);
        check("three_re_const", acc_re_a, 12'd0);
        check("three_im_const", acc_im_a, 12'd17);

        // Zero terms: done the cycle after start, accumulators cleared.
        qa.delete();
        qb.delete();
        run(0, 1, 1'b1, -1, 1'b0, 1'b0);
        check("zero_acc", {acc_re_a, acc_im_a}, 0);

        // Stall in FETCH with a stray start pulse.
        qa = '{8'h23};
        qb = '{8'h21};
        run(1, 2, 1'b0, 0, 1'b1, 1'b0);
        check("stall_re_const", acc_re_a, 12'd1);
        check("stall_im_const", acc_im_a, 12'd8);

        // Wrap: 15 x (7)(7) = 735 -> 0xDF in 8 bits.
        qa.delete();
        qb.delete();
        for (int i = 0; i < 15; i++) begin
            qa.push_back(8'h70);
            qb.push_back(8'h70);
        end
        run(15, 1, 1'b1, -1, 1'b0, 1'b0);
        check("wrap_re_w8_const", acc_re_b, 8'hDF);
        check("wrap_im_w8_const", acc_im_b, 8'h00);
        check("wrap_re_w12_const", acc_re_a, 12'd735);

        // Mid-run reset during WAIT of term 2.
        m_fixed = 4;
        issue_start(3);
        feed(8'h23, 8'h21, 0, 1'b0);
        feed(8'h22, 8'h12, 0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("pre_reset_state", st_a, S_WAIT);
        check("pre_reset_acc_re", acc_re_a, 12'd1);
        check("pre_reset_acc_im", acc_im_a, 12'd8);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_state", st_a, S_IDLE);
        check("abort_busy", busy_a, 0);
        check("abort_acc", {acc_re_a, acc_im_a}, 0);
        check("abort_w8", {busy_b, acc_re_b, acc_im_b}, 0);
        check("abort_w8_state", st_b, S_IDLE);
        inj_out  = 16'h0505;
        inj_done = 1'b1;
        @(negedge clk);
        inj_done = 1'b0;
        @(negedge clk);
        check("late_done_ignored", {acc_re_a, acc_im_a}, 0);
        check("late_done_idle", st_a, S_IDLE);

        // Randomized runs with random multiplier latency and input gaps.
        for (int r = 0; r < 12; r++) begin
            n = (r % 4 == 3) ? int'($urandom_range(7, 15)) : int'($urandom_range(1, 6));
            qa.delete();
            qb.delete();
            for (int i = 0; i < n; i++) begin
                qa.push_back({4'($urandom_range(0, 7)), 4'($urandom_range(0, 7))});
                qb.push_back({4'($urandom_range(0, 7)), 4'($urandom_range(0, 7))});
            end
            run(n, 0, 1'b0, -1, 1'b0, 1'b1);
        end

        repeat (3) @(negedge clk);
        check("pending_results", exp_re_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/cmpx_mac_seq.md
# cmpx_mac_seq

Sequencer and accumulator that sits directly downstream of the 4x4 complex multiplier (`Mult4x4Cmpx`). It accepts a stream of complex operand pairs, issues each pair to the multiplier with a start/done handshake, and adds each 16-bit `{re, im}` product into signed complex accumulators. At the end of the run it reports the sum of N complex products.

## Interface
- `ACC_W`, default 12: accumulator width per component (signed, two's complement); must be ≥ 8.
- `CNT_W`, default 4: width of the term count; the maximum run length is 2^CNT_W − 1 terms.
- `clk` in, 1: the single clock, rising edge.
- `rst` in, 1: synchronous, active-high reset.
- `start` in, 1: begins a run; sampled only in IDLE.
- `n_terms` in, CNT_W: number of products to accumulate; sampled with `start`.
- `in_valid` in, 1: an operand pair is present on `a_in`/`b_in`.
- `a_in` in, 8: operand A as {re[7:4], im[3:0]}, unsigned nibbles.
- `b_in` in, 8: operand B, same packing as `a_in`.
- `in_ready` out, 1: the block accepts a pair this cycle.
- `mult_a` out, 8: registered operand A to the multiplier.
- `mult_b` out, 8: registered operand B to the multiplier.
- `mult_start` out, 1: one-cycle start pulse to the multiplier.
- `mult_done` in, 1: multiplier result valid.
- `mult_out` in, 16: multiplier product {re[15:8], im[7:0]}, each field signed 8-bit.
- `acc_re` out, ACC_W: real accumulator.
- `acc_im` out, ACC_W: imaginary accumulator.
- `busy` out, 1: a run is in progress (high in every state except IDLE).
- `done` out, 1: one-cycle pulse; the accumulators hold the final result.

## Operation
- **IDLE**
  - `start`=1 with `n_terms`≠0: load the counter with `n_terms`, clear both accumulators, go to FETCH.
  - `start`=1 with `n_terms`=0: clear both accumulators, go to DONE.
- **FETCH**
  - `in_ready`=1.
  - On `in_valid`=1: register `a_in`/`b_in` into `mult_a`/`mult_b`, go to ISSUE.
  - With `in_valid`=0: stall here indefinitely.
- **ISSUE**: `mult_start`=1 for exactly one cycle, then go to SETTLE.
- **SETTLE**: one cycle; `mult_done` is ignored here, so a stale done level from the multiplier's idle state is not captured. Go to WAIT.
- **WAIT**: hold until `mult_done`=1, then capture `mult_out` and go to ACC.
- **ACC**
  - Sign-extend `mult_out[15:8]` to ACC_W and add it into `acc_re`.
  - Sign-extend `mult_out[7:0]` to ACC_W and add it into `acc_im`.
  - Decrement the counter. If the counter reaches 0, go to DONE; otherwise go to FETCH.
- **DONE**: `done`=1 for one cycle, then go to IDLE. The accumulators hold their value until the next accepted `start`.
- Arithmetic: sums wrap modulo 2^ACC_W; there is no saturation and no overflow flag.
- The operand domain is 0..7 per nibble, which keeps every product field within signed 8-bit range. Callers must stay in this domain.
- `start` asserted outside IDLE is ignored.
- `mult_a`/`mult_b` stay stable from ISSUE through ACC.

## Timing
- Reset values:
  - State = IDLE.
  - `in_ready`, `mult_start`, `busy`, `done` = 0.
  - `mult_a`, `mult_b`, `acc_re`, `acc_im`, counter = 0.
- Reset mid-run aborts on the next edge:
  - The block returns to IDLE and the accumulators clear.
  - A later `mult_done` is ignored because the block is in IDLE.
  - The multiplier is reset by the shared `rst`.
- Per-term latency: 1 (FETCH, if `in_valid` is already high) + 1 (ISSUE) + 1 (SETTLE) + M (WAIT, the multiplier latency, M ≥ 1) + 1 (ACC).
- Run latency: the `start` edge to `done` takes 1 + N·(4+M) cycles when `in_valid` is held high.
- Accumulator timing: the new accumulator value is visible the cycle after ACC. With `n_terms`=0, `done` rises the cycle after `start`.
- `in_ready` is combinational from the state register only, never from `in_valid`.

## Structure
- Package `cmpx_mac_pkg` holds:
  - the state enum (IDLE, FETCH, ISSUE, SETTLE, WAIT, ACC, DONE);
  - OP_W=8 and PROD_W=16;
  - the field-slice constants for the re/im halves.
- Sub-module `cmpx_acc_reg` is instantiated twice (re, im). It is an ACC_W register with a synchronous clear, and a load of `acc + sext(prod8)`.
- The top level holds the FSM, the counter, and the operand registers. It is wired to `Mult4x4Cmpx` in the integration bench.

## Test plan
- **Single term**: `n_terms`=1, a={2,3}, b={2,1} → `done` pulse with `acc_re`=1, `acc_im`=8.
- **Three terms**: `n_terms`=3, pairs ({2,3},{2,1}), ({2,2},{1,2}), ({1,0},{1,3}) → `acc_re`=0, `acc_im`=17, `done` high for exactly 1 cycle.
- **Zero terms**: `n_terms`=0 → `done` the cycle after `start`, both accumulators 0, `mult_start` never asserted.
- **Stall plus ignored start**: `in_valid` low for 5 cycles in FETCH with `start` pulsed mid-run → no extra `mult_start`, result unchanged (1, 8).
- **Wrap**: ACC_W=8, `n_terms`=15, every pair ({7,0},{7,0}) → `acc_re`=8'hDF (735 mod 256), `acc_im`=0.
- **Mid-run reset**: `rst` asserted in WAIT of term 2 → next cycle IDLE, `busy`=0, `acc_re`/`acc_im`=0; a following `mult_done` does not change the accumulators.
